// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator. Each channel emits num strobes
// per den refclk cycles. A new ratio takes effect at the channel's next strobe.
module clk_en_gen #(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned ACC_W       = 24,
    parameter  int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    input  logic              sync,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);
    localparam int unsigned       LOCK_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  num_q  [NUM_CH];
    logic [ACC_W-1:0]  num_d  [NUM_CH];
    logic [ACC_W-1:0]  den_q  [NUM_CH];
    logic [ACC_W-1:0]  den_d  [NUM_CH];
    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [ACC_W-1:0]  pnum_q [NUM_CH];
    logic [ACC_W-1:0]  pnum_d [NUM_CH];
    logic [ACC_W-1:0]  pden_q [NUM_CH];
    logic [ACC_W-1:0]  pden_d [NUM_CH];
    logic [NUM_CH-1:0] pval_q, pval_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic              locked_q, locked_d;

    logic [ACC_W-1:0]  eff_num [NUM_CH];
    logic [ACC_W:0]    sum     [NUM_CH];
    logic [NUM_CH-1:0] active, roll, apply;

    // Clamping num to den makes the accumulator stay at its value and roll every cycle.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            active[i]  = (num_q[i] != '0) && (den_q[i] != '0);
            eff_num[i] = (num_q[i] > den_q[i]) ? den_q[i] : num_q[i];
            sum[i]     = {1'b0, acc_q[i]} + {1'b0, eff_num[i]};
            roll[i]    = active[i] && (sum[i] >= {1'b0, den_q[i]});
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            num_d[i]  = num_q[i];
            den_d[i]  = den_q[i];
            acc_d[i]  = acc_q[i];
            pnum_d[i] = pnum_q[i];
            pden_d[i] = pden_q[i];
        end
        pval_d = pval_q;
        ce_d   = '0;
        apply  = '0;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sync) begin
                acc_d[i] = '0;
                apply[i] = pval_q[i];
            end else if (!active[i]) begin
                apply[i] = pval_q[i];
            end else begin
                ce_d[i]  = roll[i];
                apply[i] = roll[i] & pval_q[i];
                acc_d[i] = roll[i] ? ACC_W'(sum[i] - {1'b0, den_q[i]}) : ACC_W'(sum[i]);
            end

            if (apply[i]) begin
                num_d[i]  = pnum_q[i];
                den_d[i]  = pden_q[i];
                acc_d[i]  = '0;
                pval_d[i] = 1'b0;
            end

            // A write landing on an apply edge is evaluated after it, so it stays pending.
            if (cfg_we && (32'(cfg_ch) == i)) begin
                pnum_d[i] = cfg_num;
                pden_d[i] = cfg_den;
                pval_d[i] = 1'b1;
            end
        end

        if (sync || (apply != '0)) begin
            lock_d = LOCK_INIT;
        end else if (lock_q != '0) begin
            lock_d = lock_q - LOCK_W'(1);
        end else begin
            lock_d = lock_q;
        end
        locked_d = (lock_q == '0);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                num_q[i]  <= '0;
                den_q[i]  <= '0;
                acc_q[i]  <= '0;
                pnum_q[i] <= '0;
                pden_q[i] <= '0;
            end
            pval_q   <= '0;
            ce_q     <= '0;
            lock_q   <= LOCK_INIT;
            locked_q <= 1'b0;
        end else begin
            num_q    <= num_d;
            den_q    <= den_d;
            acc_q    <= acc_d;
            pnum_q   <= pnum_d;
            pden_q   <= pden_d;
            pval_q   <= pval_d;
            ce_q     <= ce_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    assign ce     = ce_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomized and directed bench for clk_en_gen, checked against a model that
// derives strobe times from floor(k*num/den) steps since the channel's phase origin.
module tb_clk_en_gen;
    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 8;
    localparam int unsigned LC  = 6;
    localparam int unsigned CHW = 2;

    logic           refclk = 1'b0;
    logic           rst, cfg_we, sync;
    logic [CHW-1:0] cfg_ch;
    logic [AW-1:0]  cfg_num, cfg_den;
    logic [NCH-1:0] ce;
    logic           locked;

    int checks   = 0;
    int failures = 0;
    longint cyc  = 0;

    clk_en_gen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg_we (cfg_we),
        .cfg_ch (cfg_ch),
        .cfg_num(cfg_num),
        .cfg_den(cfg_den),
        .sync   (sync),
        .ce     (ce),
        .locked (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: applied ratio, pending ratio and edges elapsed since phase origin.
    longint         m_n [NCH], m_d [NCH], m_pn [NCH], m_pd [NCH], m_k [NCH];
    bit             m_pv [NCH];
    int unsigned    m_since = 0;
    logic [NCH-1:0] exp_ce = '0;
    logic           exp_locked = 1'b0;

    task automatic model_edge();
        logic [NCH-1:0] nce;
        bit     ev;
        bit     act;
        longint ne;
        nce = '0;
        ev  = 1'b0;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_n[i] = 0; m_d[i] = 0; m_pn[i] = 0; m_pd[i] = 0; m_k[i] = 0; m_pv[i] = 0;
            end
            exp_ce     = '0;
            exp_locked = 1'b0;
            m_since    = 0;
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            act = (m_n[i] != 0) && (m_d[i] != 0);
            if (sync) begin
                m_k[i] = 0;
                if (m_pv[i]) begin m_n[i] = m_pn[i]; m_d[i] = m_pd[i]; m_pv[i] = 0; end
            end else if (!act) begin
                if (m_pv[i]) begin
                    m_n[i] = m_pn[i]; m_d[i] = m_pd[i]; m_pv[i] = 0; m_k[i] = 0; ev = 1'b1;
                end
            end else begin
                ne = (m_n[i] > m_d[i]) ? m_d[i] : m_n[i];
                m_k[i]++;
                if ((m_k[i] * ne) / m_d[i] != ((m_k[i] - 1) * ne) / m_d[i]) begin
                    nce[i] = 1'b1;
                    if (m_pv[i]) begin
                        m_n[i] = m_pn[i]; m_d[i] = m_pd[i]; m_pv[i] = 0; m_k[i] = 0; ev = 1'b1;
                    end
                end
            end
            if (cfg_we && (int'(cfg_ch) == i)) begin
                m_pn[i] = longint'(cfg_num);
                m_pd[i] = longint'(cfg_den);
                m_pv[i] = 1'b1;
            end
        end
        exp_locked = (m_since >= LC);
        if (ev || sync) m_since = 0;
        else if (m_since < 100000) m_since++;
        exp_ce = nce;
    endtask

    task automatic step();
        model_edge();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic drive_cfg(input int ch, input int n, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_num = AW'(n);
        cfg_den = AW'(d);
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; sync = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
        step();
        step();
        checks++;
        if (ce !== '0 || locked !== 1'b0) begin failures++;
            $display("FAIL reset_state ce=%b locked=%b expected ce=000 locked=0", ce, locked); end
        rst = 1'b0;
        for (int j = 1; j <= int'(LC) + 3; j++) begin
            step();
            checks++;
            if (ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL reset_model cyc=%0d ce=%b locked=%b expected ce=%b locked=%b", cyc, ce, locked, exp_ce, exp_locked); end
        end
        checks++;
        if (locked !== 1'b1) begin failures++;
            $display("FAIL reset_lock_rise locked=%b expected 1", locked); end
    endtask

    task automatic test_t1();
        int first, cnt;
        first = -1;
        cnt   = 0;
        drive_cfg(0, 1, 4);
        step();
        cfg_we = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            checks++;
            if (ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL t1_model cyc=%0d ce=%b locked=%b expected ce=%b locked=%b", cyc, ce, locked, exp_ce, exp_locked); end
            if (ce[0]) begin cnt++; if (first < 0) first = j; end
        end
        checks++;
        if (first != 5) begin failures++; $display("FAIL t1_first_pulse at=%0d expected 5", first); end
        checks++;
        if (cnt != 4) begin failures++; $display("FAIL t1_pulse_count got=%0d expected 4", cnt); end
    endtask

    task automatic test_t2();
        int win, total;
        win   = 0;
        total = 0;
        drive_cfg(1, 3, 8);
        step();
        cfg_we = 1'b0;
        step();
        for (int j = 1; j <= 800; j++) begin
            step();
            checks++;
            if (ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL t2_model cyc=%0d ce=%b locked=%b expected ce=%b locked=%b", cyc, ce, locked, exp_ce, exp_locked); end
            if (ce[1]) begin win++; total++; end
            if (j % 8 == 0) begin
                checks++;
                if (win != 3) begin failures++; $display("FAIL t2_window end=%0d got=%0d expected 3", j, win); end
                win = 0;
            end
        end
        checks++;
        if (total != 300) begin failures++; $display("FAIL t2_total got=%0d expected 300", total); end
    endtask

    task automatic test_t3();
        drive_cfg(2, 5, 5);
        step();
        cfg_we = 1'b0;
        step();
        for (int j = 1; j <= 20; j++) begin
            step();
            checks++;
            if (ce[2] !== 1'b1 || ce !== exp_ce) begin failures++;
                $display("FAIL t3_equal cyc=%0d ce=%b expected ce=%b with ce[2]=1", cyc, ce, exp_ce); end
        end
        drive_cfg(2, 9, 5);
        step();
        cfg_we = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            checks++;
            if (ce[2] !== 1'b1 || ce !== exp_ce) begin failures++;
                $display("FAIL t3_clamp cyc=%0d ce=%b expected ce=%b with ce[2]=1", cyc, ce, exp_ce); end
        end
    endtask

    task automatic test_t4();
        bit found;
        bit e_ce, e_lk;
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            step();
            if (locked && ce[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t4_wait_pulse found=0 expected 1"); end
        drive_cfg(0, 1, 2);
        step();
        cfg_we = 1'b0;
        for (int j = 1; j <= int'(LC) + 8; j++) begin
            step();
            e_ce = (j >= 3) && ((j - 3) % 2 == 0);
            e_lk = (j <= 3) || (j >= 3 + int'(LC) + 1);
            checks++;
            if (ce[0] !== e_ce || locked !== e_lk || ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL t4_retime j=%0d ce=%b locked=%b expected ce[0]=%b locked=%b ce=%b", j, ce, locked, e_ce, e_lk, exp_ce); end
        end
    endtask

    task automatic test_t5();
        drive_cfg(0, 1, 3);
        step();
        drive_cfg(1, 1, 5);
        step();
        cfg_we = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            checks++;
            if (ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL t5_model cyc=%0d ce=%b locked=%b expected ce=%b locked=%b", cyc, ce, locked, exp_ce, exp_locked); end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (ce !== '0 || locked !== exp_locked) begin failures++;
            $display("FAIL t5_sync_clear ce=%b locked=%b expected ce=000 locked=%b", ce, locked, exp_locked); end
        for (int j = 1; j <= 6; j++) begin
            step();
            checks++;
            if (ce[0] !== (j % 3 == 0) || ce[1] !== (j == 5) || ce !== exp_ce) begin failures++;
                $display("FAIL t5_align j=%0d ce=%b expected ce0=%0d ce1=%0d ce=%b", j, ce, (j % 3 == 0), (j == 5), exp_ce); end
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        bit e;
        drive_cfg(2, 2, 2);
        step();
        drive_cfg(2, 1, 4);
        step();
        cfg_we = 1'b0;
        for (int j = 2; j <= 14; j++) begin
            step();
            e = (j <= 2) || (j >= 6 && (j - 6) % 4 == 0);
            checks++;
            if (ce[2] !== e || ce !== exp_ce) begin failures++;
                $display("FAIL b2b_apply_write j=%0d ce=%b expected ce[2]=%b ce=%b", j, ce, e, exp_ce); end
        end
        found = 1'b0;
        for (int n = 0; n < 32 && !found; n++) begin
            step();
            if (ce[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL b2b_wait_pulse found=0 expected 1"); end
        drive_cfg(1, 1, 2);
        step();
        drive_cfg(1, 1, 3);
        step();
        drive_cfg(3, 1, 1);
        step();
        cfg_we = 1'b0;
        for (int j = 4; j <= 14; j++) begin
            step();
            e = (j == 5) || (j >= 8 && (j - 8) % 3 == 0);
            checks++;
            if (ce[1] !== e || ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL b2b_overwrite j=%0d ce=%b locked=%b expected ce[1]=%b ce=%b locked=%b", j, ce, locked, e, exp_ce, exp_locked); end
        end
    endtask

    task automatic test_rst_mid();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 32 && !found; n++) begin
            step();
            if (ce[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rst_wait_pulse found=0 expected 1"); end
        drive_cfg(1, 1, 5);
        step();
        cfg_we = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (ce !== '0 || locked !== 1'b0) begin failures++;
            $display("FAIL rst_mid ce=%b locked=%b expected ce=000 locked=0", ce, locked); end
        for (int j = 1; j <= 30; j++) begin
            step();
            checks++;
            if (ce !== '0 || ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL rst_silent j=%0d ce=%b locked=%b expected ce=000 locked=%b", j, ce, locked, exp_locked); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 499) == 0);
            sync    = ($urandom_range(0, 63) == 0);
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_ch  = CHW'($urandom_range(0, 3));
            cfg_num = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 12));
            cfg_den = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 12));
            step();
            checks++;
            if (ce !== exp_ce || locked !== exp_locked) begin failures++;
                $display("FAIL random_model cyc=%0d ce=%b locked=%b expected ce=%b locked=%b", cyc, ce, locked, exp_ce, exp_locked); end
        end
        rst = 1'b0; sync = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_t1();
        test_t2();
        test_t3();
        test_t4();
        test_t5();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d expected completion", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
